// File: rtl/aging_mon_pkg.sv
// Shared types and constants for the aging-sensor measurement controller.
package aging_mon_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StMeasure,
      StEval,
      StReport
   } state_e;

   localparam logic [1:0] LVL_OK   = 2'd0;
   localparam logic [1:0] LVL_DEGR = 2'd1;
   localparam logic [1:0] LVL_CRIT = 2'd2;

endpackage

// File: rtl/aging_evt_counter.sv
// Saturating event counter with synchronous clear (clear beats count-enable).
module aging_evt_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/aging_monitor_ctrl.sv
// Aging-sensor measurement sequencer: timed window, warning count, two-threshold
// grading and a sticky alarm after repeated critical grades.
module aging_monitor_ctrl
   import aging_mon_pkg::*;
#(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned WIN_W      = 16,
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned ALARM_CNT  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic [WIN_W-1:0] cfg_period,
   input  logic [WIN_W-1:0] cfg_window,
   input  logic [CNT_W-1:0] cfg_thr_lo,
   input  logic [CNT_W-1:0] cfg_thr_hi,
   input  logic             alarm_clr,
   input  logic             warning_signal,
   output logic             sensor_en,
   output logic             busy,
   output logic             result_valid,
   output logic [CNT_W-1:0] result_count,
   output logic [1:0]       aging_level,
   output logic             alarm
);

   localparam int unsigned HitW       = $clog2(ALARM_CNT + 1);
   localparam int unsigned SettleLast = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
   localparam logic [HitW-1:0] HitMax = HitW'(ALARM_CNT);

   state_e           state_q, state_d;
   logic [WIN_W-1:0] period_q, period_d;
   logic [WIN_W-1:0] tmr_q, tmr_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [CNT_W-1:0] thr_lo_q, thr_lo_d;
   logic [CNT_W-1:0] thr_hi_q, thr_hi_d;
   logic [CNT_W-1:0] result_count_q, result_count_d;
   logic [1:0]       aging_level_q, aging_level_d;
   logic [HitW-1:0]  hit_q, hit_d;
   logic             alarm_q, alarm_d;

   logic [CNT_W-1:0] cnt;
   logic             auto_hit;
   logic             trigger;
   logic             cnt_en;
   logic [1:0]       grade;
   logic [HitW-1:0]  hit_inc;
   logic             set_now;

   aging_evt_counter #(
      .CNT_W (CNT_W)
   ) u_win_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (trigger),
      .en    (cnt_en),
      .count (cnt)
   );

   always_comb begin
      auto_hit = (cfg_period != '0) && (period_q == (cfg_period - WIN_W'(1)));
      trigger  = (state_q == StIdle) && enable && (start || auto_hit);
      cnt_en   = (state_q == StMeasure) && warning_signal;

      // High threshold is checked first, so thr_lo > thr_hi yields only 0 or 2.
      if (cnt >= thr_hi_q) begin
         grade = LVL_CRIT;
      end else if (cnt >= thr_lo_q) begin
         grade = LVL_DEGR;
      end else begin
         grade = LVL_OK;
      end

      hit_inc = (hit_q == HitMax) ? HitMax : hit_q + HitW'(1);
      set_now = (state_q == StReport) && (aging_level_q == LVL_CRIT) && (hit_inc == HitMax);
   end

   always_comb begin
      state_d        = state_q;
      period_d       = period_q;
      tmr_d          = tmr_q;
      win_d          = win_q;
      thr_lo_d       = thr_lo_q;
      thr_hi_d       = thr_hi_q;
      result_count_d = result_count_q;
      aging_level_d  = aging_level_q;
      hit_d          = hit_q;
      alarm_d        = alarm_q;

      unique case (state_q)
         StIdle: begin
            if (enable && (cfg_period != '0)) begin
               period_d = period_q + WIN_W'(1);
            end
            if (trigger) begin
               period_d = '0;
               tmr_d    = '0;
               win_d    = (cfg_window == '0) ? WIN_W'(1) : cfg_window;
               thr_lo_d = cfg_thr_lo;
               thr_hi_d = cfg_thr_hi;
               state_d  = (SETTLE_CYC > 0) ? StSettle : StMeasure;
            end
         end
         StSettle: begin
            if (tmr_q == WIN_W'(SettleLast)) begin
               tmr_d   = '0;
               state_d = StMeasure;
            end else begin
               tmr_d = tmr_q + WIN_W'(1);
            end
         end
         StMeasure: begin
            if (tmr_q == (win_q - WIN_W'(1))) begin
               state_d = StEval;
            end else begin
               tmr_d = tmr_q + WIN_W'(1);
            end
         end
         StEval: begin
            // Loaded here so the new values appear in the same cycle as result_valid.
            if (enable) begin
               result_count_d = cnt;
               aging_level_d  = grade;
            end
            state_d = StReport;
         end
         StReport: begin
            hit_d   = (aging_level_q == LVL_CRIT) ? hit_inc : '0;
            state_d = StIdle;
            if (set_now) begin
               alarm_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (!enable && (state_q != StIdle)) begin
         state_d = StIdle;
      end

      if (alarm_clr && !set_now) begin
         alarm_d = 1'b0;
         hit_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         period_q       <= '0;
         tmr_q          <= '0;
         win_q          <= '0;
         thr_lo_q       <= '0;
         thr_hi_q       <= '0;
         result_count_q <= '0;
         aging_level_q  <= LVL_OK;
         hit_q          <= '0;
         alarm_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         period_q       <= period_d;
         tmr_q          <= tmr_d;
         win_q          <= win_d;
         thr_lo_q       <= thr_lo_d;
         thr_hi_q       <= thr_hi_d;
         result_count_q <= result_count_d;
         aging_level_q  <= aging_level_d;
         hit_q          <= hit_d;
         alarm_q        <= alarm_d;
      end
   end

   assign sensor_en    = (state_q == StSettle) || (state_q == StMeasure);
   assign busy         = (state_q != StIdle);
   assign result_valid = (state_q == StReport);
   assign result_count = result_count_q;
   assign aging_level  = aging_level_q;
   // The setting REPORT cycle already shows the alarm alongside result_valid.
   assign alarm        = alarm_q | set_now;

endmodule

// File: tb/tb_aging_monitor_ctrl.sv
// Scoreboard bench for aging_monitor_ctrl: directed measurements queue expected
// results; a negedge monitor checks each result_valid against the queue.
module tb_aging_monitor_ctrl;

   localparam int S = 2;

   typedef struct packed {
      logic [7:0] cnt;
      logic [1:0] lvl;
      logic       alarm;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        start;
   logic [15:0] cfg_period;
   logic [15:0] cfg_window;
   logic [7:0]  cfg_thr_lo;
   logic [7:0]  cfg_thr_hi;
   logic        alarm_clr;
   logic        warning_signal;
   logic        sensor_en;
   logic        busy;
   logic        result_valid;
   logic [7:0]  result_count;
   logic [1:0]  aging_level;
   logic        alarm;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   aging_monitor_ctrl #(
      .CNT_W      (8),
      .WIN_W      (16),
      .SETTLE_CYC (S),
      .ALARM_CNT  (3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .start          (start),
      .cfg_period     (cfg_period),
      .cfg_window     (cfg_window),
      .cfg_thr_lo     (cfg_thr_lo),
      .cfg_thr_hi     (cfg_thr_hi),
      .alarm_clr      (alarm_clr),
      .warning_signal (warning_signal),
      .sensor_en      (sensor_en),
      .busy           (busy),
      .result_valid   (result_valid),
      .result_count   (result_count),
      .aging_level    (aging_level),
      .alarm          (alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (!reset && result_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got count=%0d level=%0d, expected no result",
                     result_count, aging_level);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result_count", 32'(result_count), 32'(e.cnt));
            chk("aging_level", 32'(aging_level), 32'(e.lvl));
            chk("alarm_at_result", 32'(alarm), 32'(e.alarm));
         end
      end
   end

   // One start-triggered measurement with per-cycle timing checks.
   task automatic measure(input int w, input int nwarn, input int lo, input int hi,
                          input int exp_cnt, input int exp_lvl, input bit exp_alarm,
                          input bit clr_at_rep, input bit start_mid);
      int   we;
      int   last;
      exp_t e;
      we    = (w == 0) ? 1 : w;
      last  = S + we + 2;
      e.cnt = 8'(exp_cnt);
      e.lvl = 2'(exp_lvl);
      e.alarm = exp_alarm;
      exp_q.push_back(e);
      chk("idle_before", 32'(busy), 0);
      cfg_window = 16'(w);
      cfg_thr_lo = 8'(lo);
      cfg_thr_hi = 8'(hi);
      start      = 1'b1;
      cyc(1);
      start      = 1'b0;
      // Scramble config after the trigger: the latched copy must be used.
      cfg_window = 16'd3;
      cfg_thr_lo = 8'hff;
      cfg_thr_hi = 8'hff;
      for (int k = 1; k <= last; k++) begin
         if (k <= S) warning_signal = 1'b1;
         else if (k <= S + we) warning_signal = (k - S - 1) < nwarn;
         else warning_signal = 1'b0;
         start     = start_mid && (k == S + 2);
         alarm_clr = clr_at_rep && (k == last);
         chk("sensor_en", 32'(sensor_en), 32'(k <= S + we));
         chk("result_valid", 32'(result_valid), 32'(k == last));
         chk("busy", 32'(busy), 1);
         cyc(1);
      end
      warning_signal = 1'b0;
      start          = 1'b0;
      alarm_clr      = 1'b0;
      chk("busy_after", 32'(busy), 0);
      chk("valid_after", 32'(result_valid), 0);
      cyc(2);
      chk("still_idle", 32'(busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int   n;
      int   p;
      exp_t e;
      reset          = 1'b1;
      enable         = 1'b1;
      start          = 1'b0;
      cfg_period     = '0;
      cfg_window     = '0;
      cfg_thr_lo     = '0;
      cfg_thr_hi     = '0;
      alarm_clr      = 1'b0;
      warning_signal = 1'b0;
      cyc(3);
      chk("rst_sensor_en", 32'(sensor_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(result_valid), 0);
      chk("rst_count", 32'(result_count), 0);
      chk("rst_level", 32'(aging_level), 0);
      chk("rst_alarm", 32'(alarm), 0);
      reset = 1'b0;
      cyc(2);

      //       w    nw   lo  hi   cnt  lvl alarm clr mid
      measure(10,   5,   4,  8,   5,   1,  0,    0,  0);
      measure(300,  300, 4,  200, 255, 2,  0,    0,  0);
      measure(0,    1,   1,  2,   1,   1,  0,    0,  0);
      measure(4,    4,   1,  3,   4,   2,  0,    0,  1);
      measure(4,    0,   1,  3,   0,   0,  0,    0,  0);
      measure(4,    3,   1,  3,   3,   2,  0,    0,  0);
      measure(4,    4,   1,  3,   4,   2,  0,    0,  0);
      measure(5,    5,   6,  5,   5,   2,  1,    1,  0);
      chk("alarm_sticky", 32'(alarm), 1);
      alarm_clr = 1'b1;
      cyc(1);
      alarm_clr = 1'b0;
      chk("alarm_cleared", 32'(alarm), 0);
      measure(4,    4,   6,  5,   4,   0,  0,    0,  0);
      measure(2,    2,   1,  2,   2,   2,  0,    0,  0);
      measure(2,    2,   1,  2,   2,   2,  0,    0,  0);
      measure(2,    2,   1,  2,   2,   2,  1,    0,  0);
      chk("alarm_held", 32'(alarm), 1);

      // Abort by enable low in MEASURE cycle 3.
      cfg_window = 16'd10;
      start      = 1'b1;
      cyc(1);
      start          = 1'b0;
      warning_signal = 1'b1;
      cyc(S + 2);
      chk("abort_in_measure", 32'(sensor_en), 1);
      enable = 1'b0;
      cyc(1);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_sensor_en", 32'(sensor_en), 0);
      warning_signal = 1'b0;
      cyc(3);
      enable = 1'b1;
      cyc(3);
      chk("abort_count_kept", 32'(result_count), 2);
      chk("abort_level_kept", 32'(aging_level), 2);
      chk("abort_alarm_kept", 32'(alarm), 1);

      // Reset in MEASURE cycle 2.
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(S + 1);
      chk("pre_reset_measure", 32'(sensor_en), 1);
      reset      = 1'b1;
      cfg_period = 16'd20;
      cfg_window = 16'd1;
      cfg_thr_lo = 8'd1;
      cfg_thr_hi = 8'd2;
      cyc(1);
      chk("mid_rst_sensor_en", 32'(sensor_en), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_valid", 32'(result_valid), 0);
      chk("mid_rst_count", 32'(result_count), 0);
      chk("mid_rst_level", 32'(aging_level), 0);
      chk("mid_rst_alarm", 32'(alarm), 0);

      // Auto-trigger every 20 IDLE cycles; two results expected.
      e.cnt   = 8'd0;
      e.lvl   = 2'd0;
      e.alarm = 1'b0;
      exp_q.push_back(e);
      exp_q.push_back(e);
      reset = 1'b0;
      n = 0;
      while (!busy && n < 100) begin
         cyc(1);
         n++;
      end
      chk("first_auto_trigger", 32'(n), 20);
      p = 0;
      while (busy && p < 100) begin
         cyc(1);
         p++;
      end
      while (!busy && p < 200) begin
         cyc(1);
         p++;
      end
      chk("auto_period", 32'(p), 25);
      cfg_period = '0;
      cyc(40);
      chk("no_third_auto", 32'(busy), 0);
      chk("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
